// File: rtl/data_mem_io_if.sv
// CPU-to-data-memory bus: address/write-back word, store data, store enable and load select.
// memwr is a single-cycle store strobe (no ready/backpressure): the store always completes on the edge where memwr=1.
interface data_mem_io_if;
    logic [31:0] alu_result;
    logic [31:0] write_data;
    logic        memwr;
    logic        memtoreg;
    logic [31:0] data;

    modport master (
        output alu_result,
        output write_data,
        output memwr,
        output memtoreg,
        input  data
    );

    modport slave (
        input  alu_result,
        input  write_data,
        input  memwr,
        input  memtoreg,
        output data
    );
endinterface

// File: rtl/data_mem_io.sv
// Data-side word RAM plus memory-mapped GPIO/timer block for a single-cycle CPU.
// Reads are combinational; RAM and register updates happen on the rising clock edge.
module data_mem_io #(
    parameter int ADDR_W = 8
) (
    input  logic              clock,
    input  logic              reset,
    data_mem_io_if.slave      bus,
    output logic [15:0]       gpio_out,
    output logic              timer_irq
);

    localparam logic [1:0] REG_GPIO    = 2'd0;
    localparam logic [1:0] REG_CYCLE   = 2'd1;
    localparam logic [1:0] REG_COMPARE = 2'd2;
    localparam logic [1:0] REG_CTRL    = 2'd3;

    logic [31:0]       ram [2**ADDR_W];
    logic [15:0]       gpio;
    logic [31:0]       cycle;
    logic [31:0]       compare;
    logic              en;
    logic              match;

    logic              is_ram;
    logic              is_mmio;
    logic [ADDR_W-1:0] ram_idx;
    logic [1:0]        reg_sel;
    logic              wr_ram;
    logic              wr_mmio;
    logic              wr_gpio;
    logic              wr_cycle;
    logic              wr_compare;
    logic              wr_ctrl;
    logic              match_hit;
    logic              match_clr;
    logic [31:0]       read_word;
    logic [1:0]        unused_byte_offset;

    // Word access only: the byte offset never takes part in decode.
    assign unused_byte_offset = bus.alu_result[1:0];

    assign is_ram  = (bus.alu_result[31:ADDR_W+2] == '0);
    assign is_mmio = (bus.alu_result[31:16] == 16'hFFFF);
    assign ram_idx = bus.alu_result[ADDR_W+1:2];
    assign reg_sel = bus.alu_result[3:2];

    assign wr_ram     = bus.memwr & is_ram;
    assign wr_mmio    = bus.memwr & is_mmio;
    assign wr_gpio    = wr_mmio & (reg_sel == REG_GPIO);
    assign wr_cycle   = wr_mmio & (reg_sel == REG_CYCLE);
    assign wr_compare = wr_mmio & (reg_sel == REG_COMPARE);
    assign wr_ctrl    = wr_mmio & (reg_sel == REG_CTRL);

    // Match test uses pre-edge EN and CYCLE; a set on the same edge beats the W1C.
    assign match_hit = en & (cycle == compare);
    assign match_clr = wr_ctrl & bus.write_data[1];

    // RAM is never reset; stores are only blocked while reset is held.
    always_ff @(posedge clock) begin
        if (reset && wr_ram) begin
            ram[ram_idx] <= bus.write_data;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            gpio    <= '0;
            cycle   <= '0;
            compare <= '0;
            en      <= 1'b0;
            match   <= 1'b0;
        end else begin
            cycle <= wr_cycle ? bus.write_data : cycle + 32'd1;
            if (wr_gpio) begin
                gpio <= bus.write_data[15:0];
            end
            if (wr_compare) begin
                compare <= bus.write_data;
            end
            if (wr_ctrl) begin
                en <= bus.write_data[0];
            end
            if (match_hit) begin
                match <= 1'b1;
            end else if (match_clr) begin
                match <= 1'b0;
            end
        end
    end

    always_comb begin
        read_word = '0;
        if (is_ram) begin
            read_word = ram[ram_idx];
        end else if (is_mmio) begin
            case (reg_sel)
                REG_GPIO:    read_word = {16'h0000, gpio};
                REG_CYCLE:   read_word = cycle;
                REG_COMPARE: read_word = compare;
                REG_CTRL:    read_word = {30'd0, match, en};
                default:     read_word = '0;
            endcase
        end
    end

    assign bus.data  = bus.memtoreg ? read_word : bus.alu_result;
    assign gpio_out  = gpio;
    assign timer_irq = match & en;

endmodule

// File: doc/data_mem_io.md
# data_mem_io

Data-side memory and I/O stage placed directly downstream of the single-cycle CPU core. It takes the CPU's address (`alu_result`), store data, `memwr` and `memtoreg`, and holds a word RAM plus a small memory-mapped timer/GPIO block. It returns the register write-back word on `data`: load data when `memtoreg`=1, otherwise `alu_result` passed through. Reads are combinational to suit the single-cycle datapath; all state updates occur on the rising clock edge.

## Interface
- `ADDR_W`, 8: RAM index width; RAM holds 2^ADDR_W 32-bit words.
- `clock`  in  1  system clock, rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `alu_result`  in  32  byte address for load/store; write-back value when `memtoreg`=0.
- `write_data`  in  32  store data.
- `memwr`  in  1  store enable, sampled at the rising edge.
- `memtoreg`  in  1  selects load data onto `data`.
- `data`  out  32  register write-back word to the CPU.
- `gpio_out`  out  16  GPIO output register.
- `timer_irq`  out  1  timer match flag AND timer enable.

## Operation
- Address decode; bits [1:0] are always ignored (word access only):
  - RAM: `alu_result[31:ADDR_W+2]`==0. Index is `alu_result[ADDR_W+1:2]`.
  - MMIO: `alu_result[31:16]`==16'hFFFF. Register is chosen by `alu_result[3:2]`. Bits [15:4] are ignored, so the 16-byte MMIO block aliases across the page.
  - Any other address: reads return 0; writes have no effect.
- MMIO registers (offsets):
  - 0x0 GPIO: RW. Bits [15:0] drive `gpio_out`; bits [31:16] read as 0.
  - 0x4 CYCLE: RW, 32-bit counter.
  - 0x8 COMPARE: RW, 32-bit.
  - 0xC CTRL: bit0 EN is RW. Bit1 MATCH is sticky and cleared by writing 1 to bit1. Other bits read 0 and ignore writes.
- Counter:
  - CYCLE increments by 1 every clock, whether or not EN is set. It wraps from FFFF_FFFF to 0.
  - A store to CYCLE loads `write_data` on that edge; there is no increment on that edge.
- Match:
  - On each edge where EN=1 and the pre-edge CYCLE equals COMPARE, MATCH is set to 1.
  - If a set and a W1C happen on the same edge, the set wins.
  - A store to CTRL writes EN and applies the W1C on the same edge. The match test on that edge uses the pre-edge EN.
- `timer_irq` = MATCH & EN. It is combinational from the registers.
- `data` = `memtoreg` ? read_word : `alu_result`. Here read_word is the RAM word, the MMIO register, or 0, according to the decode.
- Reset (`reset`=0), asynchronous:
  - GPIO, CYCLE, COMPARE, EN and MATCH go to 0. So `gpio_out`=0 and `timer_irq`=0 immediately.
  - RAM contents are not reset and are unaffected by reset.
  - While reset is held, stores are ignored and CYCLE stays 0.

## Timing
- Load latency: 0 cycles. `data` follows `alu_result`, `memtoreg` and the stored state combinationally.
- Store latency: 1 edge. A store with `memwr`=1 updates the RAM word or register on that rising edge. A load of the same address in the next cycle returns the new value.
- Read-during-write in the same cycle returns the old value, because the update happens only at the edge.
- CYCLE read value:
  - First edge after reset release: CYCLE=1.
  - N edges after release: CYCLE=N, modulo 2^32.
- MATCH is set on the edge that ends the cycle in which CYCLE==COMPARE. `timer_irq` rises right after that edge.
- Reset assertion in mid-cycle has effect immediately. Deassertion is taken synchronously by the design: the first update happens on the first rising edge with `reset`=1.

## Test plan
- RAM: store 0xDEADBEEF at 0x10 and 0x12345678 at 0x3FC (ADDR_W=8). Load both with `memtoreg`=1 -> 0xDEADBEEF and 0x12345678. Load 0x13 -> 0xDEADBEEF. Load 0x400 -> 0.
- Passthrough: `memtoreg`=0, `alu_result`=0xCAFE0001 -> `data`=0xCAFE0001. A store with `memwr`=1 to 0x8000_0000 changes nothing visible.
- Counter:
  - Release reset, wait 5 edges, load 0xFFFF0004 -> 5.
  - Store 0xFFFFFFFE to CYCLE, then load after 2 edges -> 0 (wrap). The store edge itself does not increment.
- Match and IRQ:
  - COMPARE=20, EN=1. MATCH becomes 1 after the edge where CYCLE==20, and `timer_irq`=1.
  - Write CTRL=0x3 -> MATCH=0 and EN=1.
  - Write CTRL=0x0 while MATCH=1 -> `timer_irq`=0, and CTRL reads 0x2.
- Simultaneous set and clear: W1C to MATCH on the edge where CYCLE==COMPARE with EN=1 -> MATCH stays 1.
- Reset mid-run:
  - Setup: GPIO=0xA5A5, a RAM word written, MATCH=1.
  - Assert `reset`=0 between edges -> `gpio_out`=0 and `timer_irq`=0 immediately.
  - After release, the RAM word still reads back its value and CYCLE counts up from 0.
